// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared uart types and constants
package uart_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_WAIT_BUSY,
        S_WAIT_DONE
    } tx_feed_state_t;

    localparam int UART_DATA_BITS_DEFAULT = 8;
    localparam int TX_BUSY_TIMEOUT        = 4;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// rtl/uart_tx_fifo_if.sv - producer byte handshake into the uart tx fifo
interface uart_tx_fifo_if
    import uart_pkg::*;
#(
    parameter int DATA_BITS = UART_DATA_BITS_DEFAULT
) ();

    logic [DATA_BITS-1:0] in_data;
    logic                 in_valid;
    logic                 in_ready;

    // Producer side drives data/valid and watches ready.
    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    // FIFO side consumes data/valid and reports ready.
    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );

endinterface

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - single-clock fifo with wrap-bit pointers and registered ready
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     ready,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr_nxt;
    logic [PW-1:0]    rd_ptr_nxt;
    logic [PW-1:0]    count_nxt;
    logic             full;
    logic             do_push;
    logic             do_pop;
    logic             ready_q;

    // Pointer compare: full when only the wrap bits differ, empty when identical.
    always_comb begin
        full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        empty      = (wr_ptr == rd_ptr);
        do_push    = push && ready_q && !full;
        do_pop     = pop && !empty;
        wr_ptr_nxt = wr_ptr + {{AW{1'b0}}, do_push};
        rd_ptr_nxt = rd_ptr + {{AW{1'b0}}, do_pop};
        count_nxt  = wr_ptr_nxt - rd_ptr_nxt;
        count      = wr_ptr - rd_ptr;
        rd_data    = mem[rd_ptr[AW-1:0]];
        ready      = ready_q;
    end

    // Pointers advance on accepted push/pop; ready is the registered not-full of the next state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            ready_q <= 1'b0;
        end else begin
            wr_ptr  <= wr_ptr_nxt;
            rd_ptr  <= rd_ptr_nxt;
            ready_q <= (count_nxt != PW'(DEPTH));
        end
    end

    // Storage write; contents need no reset since the pointers define validity.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte fifo plus send sequencer feeding the uart transmitter
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_BITS = UART_DATA_BITS_DEFAULT,
    parameter int DEPTH     = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    uart_tx_fifo_if.slave            in_if,
    output logic [DATA_BITS-1:0]     tx_data,
    output logic                     tx_send,
    input  logic                     tx_busy,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     idle
);

    localparam int TW = (TX_BUSY_TIMEOUT > 1) ? $clog2(TX_BUSY_TIMEOUT) : 1;

    tx_feed_state_t        state;
    logic [TW-1:0]         wait_cnt;
    logic [DATA_BITS-1:0]  head_data;
    logic                  fifo_ready;
    logic                  fifo_empty;
    logic                  push;
    logic                  pop;

    uart_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push    (push),
        .wr_data (in_if.in_data),
        .pop     (pop),
        .rd_data (head_data),
        .ready   (fifo_ready),
        .empty   (fifo_empty),
        .count   (count)
    );

    // Handshake and pop qualification; pop only from idle with the line free.
    always_comb begin
        in_if.in_ready = fifo_ready;
        push           = in_if.in_valid && fifo_ready;
        pop            = (state == S_IDLE) && !fifo_empty && !tx_busy;
        idle           = fifo_empty && (state == S_IDLE) && !tx_busy;
    end

    // Sequencer: latch head byte, pulse send once, then track the uart busy window.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            tx_data  <= '0;
            tx_send  <= 1'b0;
            wait_cnt <= '0;
        end else begin
            tx_send <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        tx_data <= head_data;
                        state   <= S_SEND;
                    end
                end
                S_SEND: begin
                    tx_send  <= 1'b1;
                    wait_cnt <= '0;
                    state    <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    // A uart that never reports busy must not stall the queue.
                    if (tx_busy) begin
                        state <= S_WAIT_DONE;
                    end else if (wait_cnt == TW'(TX_BUSY_TIMEOUT - 1)) begin
                        state <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_WAIT_DONE: begin
                    if (!tx_busy) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - scoreboard bench for uart_tx_fifo with a behavioural uart stub
module tb_uart_tx_fifo;

    localparam int DATA_BITS = 8;
    localparam int DEPTH     = 16;
    localparam int BUSY_LEN  = 20;

    logic                 clock = 1'b0;
    logic                 rst_n = 1'b0;
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_send;
    logic                 tx_busy;
    logic [4:0]           count;
    logic                 idle;

    logic                 force_busy = 1'b0;
    logic                 stub_dead  = 1'b0;
    int                   busy_cnt   = 0;

    logic [7:0]           expq[$];
    int                   checks   = 0;
    int                   failures = 0;
    logic                 prev_send = 1'b0;

    always #10 clock = ~clock;

    uart_tx_fifo_if #(.DATA_BITS(DATA_BITS)) in_if ();

    uart_tx_fifo #(
        .DATA_BITS (DATA_BITS),
        .DEPTH     (DEPTH)
    ) dut (
        .clock   (clock),
        .reset   (rst_n),
        .in_if   (in_if.slave),
        .tx_data (tx_data),
        .tx_send (tx_send),
        .tx_busy (tx_busy),
        .count   (count),
        .idle    (idle)
    );

    // uart stand-in: busy for BUSY_LEN cycles after each send unless stubbed dead
    always @(posedge clock) begin
        if (tx_send && !stub_dead) busy_cnt <= BUSY_LEN;
        else if (busy_cnt > 0)     busy_cnt <= busy_cnt - 1;
    end
    assign tx_busy = force_busy || (busy_cnt != 0);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every send pulse must match the oldest expected byte
    always @(negedge clock) begin
        if (rst_n && tx_send) begin
            check("send_not_consecutive", {31'd0, prev_send}, 32'd0);
            if (expq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_send: got %0h expected none", tx_data);
            end else begin
                check("tx_data_order", {24'd0, tx_data}, {24'd0, expq.pop_front()});
            end
        end
        prev_send = rst_n && tx_send;
    end

    task automatic push_byte(input logic [7:0] b);
        int n = 0;
        in_if.in_data  = b;
        in_if.in_valid = 1'b1;
        while (!in_if.in_ready && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (!in_if.in_ready) begin
            checks++;
            failures++;
            $display("FAIL push_timeout: got in_ready=0 expected 1 for byte %0h", b);
        end else begin
            expq.push_back(b);
            @(negedge clock);
        end
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (!(idle && expq.size() == 0) && n < budget) begin
            @(negedge clock);
            n++;
        end
        check("wait_idle", {31'd0, idle}, 32'd1);
    endtask

    task automatic wait_send(input string name, input int budget);
        int n = 0;
        while (!tx_send && n < budget) begin
            @(negedge clock);
            n++;
        end
        check(name, {31'd0, tx_send}, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int  gap;
        int  n;
        logic seen_low;

        in_if.in_data  = '0;
        in_if.in_valid = 1'b0;

        // reset held for 200 ns
        #100;
        check("rst_in_ready", {31'd0, in_if.in_ready}, 32'd0);
        check("rst_count", {27'd0, count}, 32'd0);
        check("rst_tx_send", {31'd0, tx_send}, 32'd0);
        check("rst_tx_data", {24'd0, tx_data}, 32'd0);
        check("rst_idle", {31'd0, idle}, 32'd1);
        repeat (5) @(negedge clock);
        rst_n = 1'b1;
        @(negedge clock);
        check("release_in_ready", {31'd0, in_if.in_ready}, 32'd1);

        // 1: single byte, send pulse two cycles after the push edge
        in_if.in_data  = 8'h55;
        in_if.in_valid = 1'b1;
        expq.push_back(8'h55);
        @(negedge clock);
        in_if.in_valid = 1'b0;
        check("t1_count_after_push", {27'd0, count}, 32'd1);
        check("t1_send_c1", {31'd0, tx_send}, 32'd0);
        @(negedge clock);
        check("t1_send_c2", {31'd0, tx_send}, 32'd0);
        check("t1_count_after_pop", {27'd0, count}, 32'd0);
        @(negedge clock);
        check("t1_send_c3", {31'd0, tx_send}, 32'd1);
        check("t1_tx_data", {24'd0, tx_data}, 32'h55);
        @(negedge clock);
        check("t1_send_c4", {31'd0, tx_send}, 32'd0);
        wait_idle(200);

        // 2: burst of four while the line is busy, then drain in order
        force_busy = 1'b1;
        push_byte(8'hA5);
        push_byte(8'h3C);
        push_byte(8'hFF);
        push_byte(8'h00);
        in_if.in_valid = 1'b0;
        check("t2_count_peak", {27'd0, count}, 32'd4);
        force_busy = 1'b0;
        wait_idle(500);
        check("t2_count_end", {27'd0, count}, 32'd0);

        // 3: fill to DEPTH, hold the 17th byte until the first pop
        force_busy = 1'b1;
        for (int i = 0; i < DEPTH; i++) push_byte(8'h10 + 8'(i));
        check("t3_count_full", {27'd0, count}, 32'd16);
        check("t3_ready_full", {31'd0, in_if.in_ready}, 32'd0);
        in_if.in_data  = 8'hEE;
        in_if.in_valid = 1'b1;
        repeat (3) @(negedge clock);
        check("t3_held_count", {27'd0, count}, 32'd16);
        check("t3_held_ready", {31'd0, in_if.in_ready}, 32'd0);
        force_busy = 1'b0;
        @(negedge clock);
        check("t3_after_pop_count", {27'd0, count}, 32'd15);
        check("t3_after_pop_ready", {31'd0, in_if.in_ready}, 32'd1);
        expq.push_back(8'hEE);
        @(negedge clock);
        in_if.in_valid = 1'b0;
        check("t3_17th_accepted", {27'd0, count}, 32'd16);
        wait_idle(2000);

        // 4: simultaneous push and pop at count 1
        force_busy = 1'b1;
        push_byte(8'h81);
        check("t4_count_one", {27'd0, count}, 32'd1);
        in_if.in_data = 8'h82;
        force_busy    = 1'b0;
        expq.push_back(8'h82);
        @(negedge clock);
        in_if.in_valid = 1'b0;
        check("t4_count_pushpop", {27'd0, count}, 32'd1);
        wait_idle(500);

        // 5: reset mid-frame with three bytes queued
        push_byte(8'h91);
        in_if.in_valid = 1'b0;
        wait_send("t5_first_send", 100);
        push_byte(8'h92);
        push_byte(8'h93);
        push_byte(8'h94);
        in_if.in_valid = 1'b0;
        check("t5_count_three", {27'd0, count}, 32'd3);
        #3;
        rst_n = 1'b0;
        #1;
        check("t5_rst_tx_send", {31'd0, tx_send}, 32'd0);
        check("t5_rst_tx_data", {24'd0, tx_data}, 32'd0);
        check("t5_rst_count", {27'd0, count}, 32'd0);
        check("t5_uart_still_busy", {31'd0, tx_busy}, 32'd1);
        expq.delete();
        @(negedge clock);
        rst_n = 1'b1;
        push_byte(8'h95);
        in_if.in_valid = 1'b0;
        seen_low = 1'b0;
        n = 0;
        while (!tx_send && n < 200) begin
            if (!tx_busy) seen_low = 1'b1;
            @(negedge clock);
            n++;
        end
        check("t5_send_after_release", {31'd0, tx_send}, 32'd1);
        check("t5_busy_dropped_first", {31'd0, seen_low}, 32'd1);
        wait_idle(500);

        // 6: uart never reports busy, timeout releases the sequencer
        stub_dead = 1'b1;
        push_byte(8'hA1);
        push_byte(8'hA2);
        in_if.in_valid = 1'b0;
        wait_send("t6_first_send", 50);
        gap = 0;
        do begin
            @(negedge clock);
            gap++;
        end while (!tx_send && gap < 50);
        check("t6_timeout_gap", gap, 32'd6);
        wait_idle(100);
        stub_dead = 1'b0;

        check("scoreboard_empty", expq.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
